// File: rtl/pbl_mem_pkg.sv
// Shared definitions for the pipeline memory responder: FSM states,
// requester identifiers and the wait-state counter width.
package pbl_mem_pkg;

    typedef enum logic [1:0] {
        ST_OCIOSO   = 2'd0,
        ST_ESPERA   = 2'd1,
        ST_RESPOSTA = 2'd2
    } estado_t;

    localparam logic PORTA_IF  = 1'b0;
    localparam logic PORTA_MEM = 1'b1;

    // wait states range 0..15
    localparam int LARG_CONT = 4;

endpackage

// File: rtl/memoria_palavras.sv
// Unified word array shared by fetch and data accesses.
// Synchronous write, asynchronous read, contents survive reset.
module memoria_palavras #(
    parameter int LARG_DADOS = 32,
    parameter int PROF_MEM   = 256,
    parameter int LARG_END   = $clog2(PROF_MEM)
) (
    input  logic                  clock,
    input  logic                  grava,
    input  logic [LARG_END-1:0]   end_escrita,
    input  logic [LARG_DADOS-1:0] dado_escrita,
    input  logic [LARG_END-1:0]   end_leitura,
    output logic [LARG_DADOS-1:0] dado_leitura
);

    logic [LARG_DADOS-1:0] mem [PROF_MEM];

    // write port, committed on the rising edge
    always_ff @(posedge clock) begin
        if (grava) begin
            mem[end_escrita] <= dado_escrita;
        end
    end

    assign dado_leitura = mem[end_leitura];

endmodule

// File: rtl/respondedor_memoria.sv
// Memory responder for the IF and MEM pipeline stages: arbitrates between
// the two requesters, inserts programmable wait states and answers with a
// one-cycle pronto pulse.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_OCIOSO   | idle, grants mem_req first, then if_req
// ST_ESPERA   | counting wait states for the latched access
// ST_RESPOSTA | pronto high, read data out, pending write commits at its end
module respondedor_memoria
    import pbl_mem_pkg::*;
#(
    parameter int LARG_DADOS = 32,
    parameter int PROF_MEM   = 256,
    parameter int ESPERA     = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  if_req,
    input  logic [31:0]           if_endereco,
    output logic                  if_pronto,
    output logic [LARG_DADOS-1:0] if_instrucao,
    input  logic                  mem_req,
    input  logic                  mem_escreve,
    input  logic [31:0]           mem_endereco,
    input  logic [LARG_DADOS-1:0] mem_valor,
    output logic                  mem_pronto,
    output logic [LARG_DADOS-1:0] mem_dado,
    output logic                  erro_alinh,
    output logic                  parar
);

    localparam int LARG_END = $clog2(PROF_MEM);
    localparam logic [LARG_CONT-1:0] CARGA_ESPERA = LARG_CONT'(ESPERA - 1);

    estado_t               estado;
    logic [LARG_CONT-1:0]  cont;
    logic                  porta_q;
    logic                  escreve_q;
    logic                  desal_q;
    logic [LARG_END-1:0]   palavra_q;
    logic [LARG_DADOS-1:0] valor_q;

    logic                  pedido;
    logic                  entra_resposta;
    logic                  grava;
    logic                  porta_sel;
    logic                  escreve_sel;
    logic                  desal_sel;
    logic [LARG_END-1:0]   palavra_sel;
    logic [LARG_DADOS-1:0] leitura;
    logic                  unused_enderecos;

    // address bits above the array size alias onto the same words
    assign unused_enderecos = ^{if_endereco[31:LARG_END+2], mem_endereco[31:LARG_END+2]};

    assign pedido = (estado == ST_OCIOSO) && (mem_req || if_req);

    // With zero wait states the response is loaded on the granting edge,
    // so the live request must be visible before it is latched.
    always_comb begin
        porta_sel   = porta_q;
        escreve_sel = escreve_q;
        desal_sel   = desal_q;
        palavra_sel = palavra_q;
        if (estado == ST_OCIOSO) begin
            if (mem_req) begin
                porta_sel   = PORTA_MEM;
                escreve_sel = mem_escreve;
                desal_sel   = (mem_endereco[1:0] != 2'b00);
                palavra_sel = mem_endereco[LARG_END+1:2];
            end else begin
                porta_sel   = PORTA_IF;
                escreve_sel = 1'b0;
                desal_sel   = (if_endereco[1:0] != 2'b00);
                palavra_sel = if_endereco[LARG_END+1:2];
            end
        end
    end

    assign entra_resposta = (pedido && (ESPERA == 0)) ||
                            ((estado == ST_ESPERA) && (cont == '0));

    assign grava = (estado == ST_RESPOSTA) && (porta_q == PORTA_MEM) &&
                   escreve_q && !desal_q;

    memoria_palavras #(
        .LARG_DADOS (LARG_DADOS),
        .PROF_MEM   (PROF_MEM),
        .LARG_END   (LARG_END)
    ) u_memoria (
        .clock        (clock),
        .grava        (grava),
        .end_escrita  (palavra_q),
        .dado_escrita (valor_q),
        .end_leitura  (palavra_sel),
        .dado_leitura (leitura)
    );

    // sequencing FSM, wait-state down-counter and registered responses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado       <= ST_OCIOSO;
            cont         <= '0;
            porta_q      <= PORTA_IF;
            escreve_q    <= 1'b0;
            desal_q      <= 1'b0;
            palavra_q    <= '0;
            valor_q      <= '0;
            if_pronto    <= 1'b0;
            mem_pronto   <= 1'b0;
            erro_alinh   <= 1'b0;
            if_instrucao <= '0;
            mem_dado     <= '0;
        end else begin
            if_pronto    <= 1'b0;
            mem_pronto   <= 1'b0;
            erro_alinh   <= 1'b0;
            if_instrucao <= '0;
            mem_dado     <= '0;
            if (entra_resposta) begin
                if_pronto  <= (porta_sel == PORTA_IF);
                mem_pronto <= (porta_sel == PORTA_MEM);
                erro_alinh <= desal_sel;
                if ((porta_sel == PORTA_IF) && !desal_sel) begin
                    if_instrucao <= leitura;
                end
                if ((porta_sel == PORTA_MEM) && !desal_sel && !escreve_sel) begin
                    mem_dado <= leitura;
                end
            end

            case (estado)
                ST_OCIOSO: begin
                    if (pedido) begin
                        porta_q   <= porta_sel;
                        escreve_q <= escreve_sel;
                        desal_q   <= desal_sel;
                        palavra_q <= palavra_sel;
                        valor_q   <= mem_valor;
                        if (ESPERA == 0) begin
                            estado <= ST_RESPOSTA;
                        end else begin
                            estado <= ST_ESPERA;
                            cont   <= CARGA_ESPERA;
                        end
                    end
                end
                ST_ESPERA: begin
                    if (cont == '0) begin
                        estado <= ST_RESPOSTA;
                    end else begin
                        cont <= cont - 1'b1;
                    end
                end
                ST_RESPOSTA: estado <= ST_OCIOSO;
                default:     estado <= ST_OCIOSO;
            endcase
        end
    end

    assign parar = reset_n & ((if_req & ~if_pronto) | (mem_req & ~mem_pronto));

endmodule

// File: tb/tb_respondedor_memoria.sv
// Bench for respondedor_memoria: directed scenarios plus randomized accesses
// checked against a word-array reference model. A second instance runs with
// zero wait states.
module tb_respondedor_memoria;

    localparam int LD = 32;
    localparam int PM = 256;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    int          ciclo = 0;
    int          total = 0;
    int          bad = 0;

    logic        if_req, mem_req, mem_escreve;
    logic [31:0] if_endereco, mem_endereco, mem_valor;
    logic        if_pronto, mem_pronto, erro_alinh, parar;
    logic [31:0] if_instrucao, mem_dado;

    logic        b_if_req, b_mem_req, b_mem_escreve;
    logic [31:0] b_if_endereco, b_mem_endereco, b_mem_valor;
    logic        b_if_pronto, b_mem_pronto, b_erro_alinh, b_parar;
    logic [31:0] b_if_instrucao, b_mem_dado;

    logic [31:0] modelo [PM];

    respondedor_memoria #(.LARG_DADOS(LD), .PROF_MEM(PM), .ESPERA(2)) dut (
        .clock(clock), .reset_n(reset_n),
        .if_req(if_req), .if_endereco(if_endereco),
        .if_pronto(if_pronto), .if_instrucao(if_instrucao),
        .mem_req(mem_req), .mem_escreve(mem_escreve),
        .mem_endereco(mem_endereco), .mem_valor(mem_valor),
        .mem_pronto(mem_pronto), .mem_dado(mem_dado),
        .erro_alinh(erro_alinh), .parar(parar)
    );

    respondedor_memoria #(.LARG_DADOS(LD), .PROF_MEM(PM), .ESPERA(0)) dut_sem_espera (
        .clock(clock), .reset_n(reset_n),
        .if_req(b_if_req), .if_endereco(b_if_endereco),
        .if_pronto(b_if_pronto), .if_instrucao(b_if_instrucao),
        .mem_req(b_mem_req), .mem_escreve(b_mem_escreve),
        .mem_endereco(b_mem_endereco), .mem_valor(b_mem_valor),
        .mem_pronto(b_mem_pronto), .mem_dado(b_mem_dado),
        .erro_alinh(b_erro_alinh), .parar(b_parar)
    );

    always #5 clock = ~clock;

    always @(posedge clock) ciclo <= ciclo + 1;

    task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs !== esp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, esp);
        end
    endtask

    // One access on the ESPERA=2 instance; called just after a rising edge
    // with the responder idle. Expected data comes from the reference array.
    task automatic acesso(input bit pmem, input bit wr, input logic [31:0] ender,
                          input logic [31:0] val, input string tag);
        logic [31:0] esp_dado;
        bit          desal;
        bit          visto;
        int          idx;
        int          t0;
        desal    = (ender[1:0] != 2'b00);
        idx      = int'(ender[9:2]);
        esp_dado = 32'h0;
        if (!desal && !(pmem && wr)) esp_dado = modelo[idx];
        if (pmem) begin
            mem_req = 1'b1; mem_escreve = wr; mem_endereco = ender; mem_valor = val;
        end else begin
            if_req = 1'b1; if_endereco = ender;
        end
        t0    = ciclo;
        visto = 1'b0;
        for (int k = 0; k < 20 && !visto; k++) begin
            @(negedge clock);
            if ((pmem ? mem_pronto : if_pronto) === 1'b1) begin
                visto = 1'b1;
            end else begin
                verificar({tag, "_parar"}, 32'(parar), 32'd1);
                @(posedge clock); #1;
            end
        end
        if (!visto) begin
            verificar({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            verificar({tag, "_lat"}, 32'(ciclo - t0), 32'd3);
            verificar({tag, "_dado"}, pmem ? mem_dado : if_instrucao, esp_dado);
            verificar({tag, "_erro"}, 32'(erro_alinh), 32'(desal));
            verificar({tag, "_outro"}, 32'(pmem ? if_pronto : mem_pronto), 32'd0);
            verificar({tag, "_parar_fim"}, 32'(parar), 32'd0);
        end
        if (pmem && wr && !desal) modelo[idx] = val;
        @(posedge clock); #1;
        mem_req = 1'b0; if_req = 1'b0; mem_escreve = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0;
        int          mem_visto;
        int          if_visto;
        logic [31:0] r;
        logic [31:0] ender;
        bit          pmem;
        bit          wr;
        int          idx;
        logic [1:0]  off;

        if_req = 0; mem_req = 0; mem_escreve = 0;
        if_endereco = 0; mem_endereco = 0; mem_valor = 0;
        b_if_req = 0; b_mem_req = 0; b_mem_escreve = 0;
        b_if_endereco = 0; b_mem_endereco = 0; b_mem_valor = 0;

        // reset state, stall forced low even with a pending request
        repeat (2) @(posedge clock);
        #1 if_req = 1'b1;
        @(negedge clock);
        verificar("rst_parar", 32'(parar), 32'd0);
        verificar("rst_prontos", {29'd0, if_pronto, mem_pronto, erro_alinh}, 32'd0);
        verificar("rst_instr", if_instrucao, 32'd0);
        verificar("rst_dado", mem_dado, 32'd0);
        @(posedge clock); #1;
        if_req = 1'b0;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // 1: write then fetch the same word
        acesso(1, 1, 32'h10, 32'hDEADBEEF, "t1_w");
        acesso(0, 0, 32'h10, 32'h0, "t1_f");

        // 2: simultaneous requests, data port served first
        mem_req = 1'b1; mem_escreve = 1'b1; mem_endereco = 32'h0; mem_valor = 32'hCAFEF00D;
        if_req = 1'b1; if_endereco = 32'h10;
        t0 = ciclo; mem_visto = -1; if_visto = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            verificar("t2_parar", 32'(parar), (k < 7) ? 32'd1 : 32'd0);
            if (mem_pronto === 1'b1) begin
                mem_visto = ciclo - t0;
                verificar("t2_mem_dado", mem_dado, 32'h0);
            end
            if (if_pronto === 1'b1) begin
                if_visto = ciclo - t0;
                verificar("t2_if_dado", if_instrucao, modelo[4]);
            end
            @(posedge clock); #1;
            if (mem_visto >= 0) begin mem_req = 1'b0; mem_escreve = 1'b0; end
            if (if_visto >= 0) if_req = 1'b0;
        end
        verificar("t2_mem_lat", 32'(mem_visto), 32'd3);
        verificar("t2_if_lat", 32'(if_visto), 32'd7);
        modelo[0] = 32'hCAFEF00D;

        // 3: misaligned write is flagged and suppressed
        acesso(1, 1, 32'h13, 32'h12345678, "t3_w");
        acesso(1, 0, 32'h10, 32'h0, "t3_r");

        // 4: upper address bits alias
        acesso(1, 1, 32'h400, 32'hA5A5A5A5, "t4_w");
        acesso(1, 0, 32'h000, 32'h0, "t4_r");

        // 5: reset in the middle of a write aborts it
        acesso(1, 1, 32'h20, 32'h11111111, "t5_w");
        mem_req = 1'b1; mem_escreve = 1'b1; mem_endereco = 32'h20; mem_valor = 32'h22222222;
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        verificar("t5_parar", 32'(parar), 32'd0);
        verificar("t5_prontos", {29'd0, if_pronto, mem_pronto, erro_alinh}, 32'd0);
        verificar("t5_dados", if_instrucao | mem_dado, 32'd0);
        @(posedge clock); #1;
        mem_req = 1'b0; mem_escreve = 1'b0;
        reset_n = 1'b1;
        @(posedge clock); #1;
        acesso(1, 0, 32'h20, 32'h0, "t5_r");

        // 6: zero wait states, back-to-back accesses
        b_mem_req = 1'b1; b_mem_escreve = 1'b1; b_mem_endereco = 32'h0; b_mem_valor = 32'h0BADF00D;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            verificar("t6_w_pronto", 32'(b_mem_pronto), (k == 1 || k == 3) ? 32'd1 : 32'd0);
            @(posedge clock); #1;
            if (k == 1) begin b_mem_endereco = 32'h4; b_mem_valor = 32'h600DCAFE; end
            if (k == 3) begin b_mem_req = 1'b0; b_mem_escreve = 1'b0; end
        end
        b_if_req = 1'b1; b_if_endereco = 32'h0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            verificar("t6_if_pronto", 32'(b_if_pronto), (k == 1 || k == 3) ? 32'd1 : 32'd0);
            if (k == 1) verificar("t6_if_dado0", b_if_instrucao, 32'h0BADF00D);
            if (k == 3) verificar("t6_if_dado1", b_if_instrucao, 32'h600DCAFE);
            @(posedge clock); #1;
            if (k == 1) b_if_endereco = 32'h4;
            if (k == 3) b_if_req = 1'b0;
        end

        // randomized traffic over a small known-initialised region
        for (int i = 0; i < 16; i++) begin
            r = $urandom;
            ender = {r[31:10], 8'(i), 2'b00};
            acesso(1, 1, ender, $urandom, "ini");
        end
        for (int i = 0; i < 60; i++) begin
            r    = $urandom;
            pmem = 1'($urandom_range(0, 1));
            wr   = pmem & 1'($urandom_range(0, 1));
            idx  = $urandom_range(0, 15);
            off  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ender = {r[31:10], 8'(idx), off};
            acesso(pmem, wr, ender, $urandom, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
